test_prog_top: RTL and testbench

- Self-contained test program block.
- Emits a fixed stream of 32-bit words over a ready/ack "stdout" channel:
  - first the ASCII characters of a greeting string;
  - then the first FIB_COUNT Fibonacci numbers, computed at run time;
  - then it halts.
- Top-level block of the test program, used to exercise the stdout handshake and its consumer in simulation.

---
 rtl/test_prog_top.sv | 97 +++++++++
 tb/tb_test_prog_top.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/test_prog_top.sv
// Test program: streams "Hello World!\n" and then FIB_COUNT Fibonacci terms
// over a ready/ack stdout channel, then halts until the next reset.
module test_prog_top #(
  parameter int FIB_COUNT = 10
) (
  input  logic        clockInput,
  input  logic        resetInput,
  input  logic        stdOutAckInput,
  output logic        stdOutReadyOutput,
  output logic [31:0] stdOutDataOutput
);

  typedef enum logic [1:0] {STR, FIB, HALT} stateType;

  localparam logic [3:0] STR_LAST = 4'd12;
  localparam logic [8:0] FIB_LAST = 9'(FIB_COUNT);

  stateType    state, stateNext;
  logic [3:0]  strIndex;
  logic [31:0] fibA, fibB;
  logic [7:0]  fibCount;
  logic        primed;     // first post-reset fetch cycle has elapsed
  logic        transfer;
  logic [7:0]  charByte;

  // Greeting character selected by the current string index
  always_comb begin
    charByte = 8'h00;
    case (strIndex)
      4'd0:  charByte = 8'h48;
      4'd1:  charByte = 8'h65;
      4'd2:  charByte = 8'h6C;
      4'd3:  charByte = 8'h6C;
      4'd4:  charByte = 8'h6F;
      4'd5:  charByte = 8'h20;
      4'd6:  charByte = 8'h57;
      4'd7:  charByte = 8'h6F;
      4'd8:  charByte = 8'h72;
      4'd9:  charByte = 8'h6C;
      4'd10: charByte = 8'h64;
      4'd11: charByte = 8'h21;
      4'd12: charByte = 8'h0A;
      default: charByte = 8'h00;
    endcase
  end

  // Next-state: advance phase on the transfer of the last word of each phase
  always_comb begin
    stateNext = state;
    transfer  = stdOutReadyOutput & stdOutAckInput;
    case (state)
      STR:  if (transfer && strIndex == STR_LAST)
              stateNext = (FIB_COUNT > 0) ? FIB : HALT;
      FIB:  if (transfer && ({1'b0, fibCount} + 9'd1) == FIB_LAST)
              stateNext = HALT;
      HALT: stateNext = HALT;
      default: stateNext = STR;
    endcase
  end

  // State register
  always_ff @(posedge clockInput) begin
    if (resetInput) state <= STR;
    else            state <= stateNext;
  end

  // Datapath: consume on transfer, then present the next word one cycle later
  always_ff @(posedge clockInput) begin
    if (resetInput) begin
      stdOutReadyOutput <= 1'b0;
      stdOutDataOutput  <= 32'd0;
      strIndex          <= 4'd0;
      fibA              <= 32'd0;
      fibB              <= 32'd1;
      fibCount          <= 8'd0;
      primed            <= 1'b0;
    end else if (transfer) begin
      stdOutReadyOutput <= 1'b0;
      primed            <= 1'b1;
      if (state == STR) begin
        strIndex <= strIndex + 4'd1;
      end else if (state == FIB) begin
        fibA     <= fibB;
        fibB     <= fibA + fibB;
        fibCount <= fibCount + 8'd1;
      end
    end else if (!stdOutReadyOutput && state != HALT) begin
      if (primed) begin
        stdOutReadyOutput <= 1'b1;
        stdOutDataOutput  <= (state == FIB) ? fibB : {24'd0, charByte};
      end else begin
        primed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_test_prog_top.sv
// Bench for test_prog_top: three instances (FIB_COUNT 10, 0, 50) driven by a
// shared reset and per-instance ack, checked against a queue-based model.
module tb_test_prog_top;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ackS [3];
  logic        rdy  [3];
  logic [31:0] dat  [3];

  int checks = 0;
  int errors = 0;
  int mode [3];              // 0: ack low, 1: ack high, 2: random ~30%
  logic [31:0] got [3][$];
  int fcOf [3] = '{10, 0, 50};

  always #5 clk = ~clk;

  test_prog_top #(.FIB_COUNT(10)) dut0 (.clockInput(clk), .resetInput(rst),
    .stdOutAckInput(ackS[0]), .stdOutReadyOutput(rdy[0]), .stdOutDataOutput(dat[0]));
  test_prog_top #(.FIB_COUNT(0)) dut1 (.clockInput(clk), .resetInput(rst),
    .stdOutAckInput(ackS[1]), .stdOutReadyOutput(rdy[1]), .stdOutDataOutput(dat[1]));
  test_prog_top #(.FIB_COUNT(50)) dut2 (.clockInput(clk), .resetInput(rst),
    .stdOutAckInput(ackS[2]), .stdOutReadyOutput(rdy[2]), .stdOutDataOutput(dat[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Reference stream: greeting bytes, then fc Fibonacci terms (mod 2^32)
  task automatic model(input int fc, output logic [31:0] q[$]);
    logic [31:0] a, b, t;
    byte unsigned s [13] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57,
                             8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0A};
    q = {};
    foreach (s[i]) q.push_back({24'd0, s[i]});
    a = 0; b = 1;
    for (int i = 0; i < fc; i++) begin
      q.push_back(b);
      t = a + b; a = b; b = t;
    end
  endtask

  // One clock with consumer behaviour; records transfers and checks the hold rules
  task automatic cyc();
    logic pr [3]; logic pa [3]; logic [31:0] pd [3];
    for (int k = 0; k < 3; k++) begin
      pa[k] = (mode[k] == 1) ? 1'b1 :
              (mode[k] == 2) ? ($urandom_range(99) < 30) : 1'b0;
      ackS[k] = pa[k];
      pr[k] = rdy[k];
      pd[k] = dat[k];
    end
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      if (pr[k] && pa[k]) begin
        got[k].push_back(pd[k]);
        chk($sformatf("gap%0d", k), {31'd0, rdy[k]}, 32'd0);
      end else if (pr[k]) begin
        chk($sformatf("holdRdy%0d", k), {31'd0, rdy[k]}, 32'd1);
        chk($sformatf("holdDat%0d", k), dat[k], pd[k]);
      end
    end
  endtask

  task automatic doReset(input int n);
    for (int k = 0; k < 3; k++) ackS[k] = 1'b1;   // ack on reset edge must be ignored
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rstRdy%0d", k), {31'd0, rdy[k]}, 32'd0);
      chk($sformatf("rstDat%0d", k), dat[k], 32'd0);
      ackS[k] = 1'b0;
      got[k] = {};
    end
    rst = 1'b0;
  endtask

  task automatic cmpSeq(input int k, input string tag);
    logic [31:0] q[$];
    model(fcOf[k], q);
    chk($sformatf("%s_len%0d", tag, k), got[k].size(), q.size());
    for (int i = 0; i < q.size() && i < got[k].size(); i++)
      chk($sformatf("%s_w%0d_%0d", tag, k, i), got[k][i], q[i]);
  endtask

  task automatic checkHalt(input string tag);
    logic [31:0] q[$];
    for (int k = 0; k < 3; k++) begin
      model(fcOf[k], q);
      chk($sformatf("%s_rdy%0d", tag, k), {31'd0, rdy[k]}, 32'd0);
      chk($sformatf("%s_last%0d", tag, k), dat[k], q[q.size()-1]);
    end
  endtask

  initial begin
    int n;
    for (int k = 0; k < 3; k++) begin ackS[k] = 1'b0; mode[k] = 0; end
    @(posedge clk); #1;

    // Multi-cycle reset, then latency: ready rises on the second post-reset edge
    doReset(3);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) chk($sformatf("lat1Rdy%0d", k), {31'd0, rdy[k]}, 32'd0);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("lat2Rdy%0d", k), {31'd0, rdy[k]}, 32'd1);
      chk($sformatf("lat2Dat%0d", k), dat[k], 32'h48);
    end

    // Idle consumer: word held indefinitely
    for (int i = 0; i < 100; i++) cyc();
    chk("idleRdy", {31'd0, rdy[0]}, 32'd1);
    chk("idleDat", dat[0], 32'h48);
    chk("idleXfers", got[0].size(), 32'd0);

    // Continuous ack: one word every two cycles, then halt with ack still high
    for (int k = 0; k < 3; k++) mode[k] = 1;
    for (int i = 0; i < 45; i++) cyc();
    chk("rate23", got[0].size(), 32'd23);
    for (int i = 0; i < 155; i++) cyc();
    for (int k = 0; k < 3; k++) cmpSeq(k, "cont");
    if (got[2].size() > 60) chk("term48", got[2][13+47], 32'h1E8D0A40);
    else chk("term48len", got[2].size(), 32'd63);
    checkHalt("contHalt");

    // Random ack (~30%), including ack pulses during gaps and in HALT
    doReset(1);
    for (int k = 0; k < 3; k++) mode[k] = 2;
    n = 0;
    while ((got[0].size() < 23 || got[1].size() < 13 || got[2].size() < 63) && n < 3000) begin
      cyc(); n++;
    end
    chk("randBudget", {31'd0, n < 3000}, 32'd1);
    for (int i = 0; i < 30; i++) cyc();
    for (int k = 0; k < 3; k++) cmpSeq(k, "rand");
    checkHalt("randHalt");

    // Reset mid-stream while a word awaits ack after the 5th Fibonacci transfer
    doReset(1);
    mode[0] = 1; mode[1] = 0; mode[2] = 0;
    n = 0;
    while (got[0].size() < 18 && n < 200) begin cyc(); n++; end
    chk("midWait", got[0].size(), 32'd18);
    mode[0] = 0;
    cyc();
    chk("midPendRdy", {31'd0, rdy[0]}, 32'd1);
    chk("midPendDat", dat[0], 32'd8);
    doReset(1);
    for (int k = 0; k < 3; k++) mode[k] = 1;
    for (int i = 0; i < 200; i++) cyc();
    for (int k = 0; k < 3; k++) cmpSeq(k, "restart");
    checkHalt("restartHalt");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
